knn_sched: RTL

//  Sequencer for a k-nearest-neighbour search.
//  - Walks n_train training points held in an external sync-read memory.
//  - Hands each (test, train) pair to the shared distance unit over a valid/ready request channel.
//  - Keeps a sorted list of the K smallest distances plus their labels.
//  - Sits between the CPU-visible register file (start/config/results) and the distance datapath.

---
 rtl/knn_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/knn_sched.sv
// k-nearest-neighbour search sequencer: walks training memory, issues distance
// requests, and maintains a sorted list of the K closest points with labels.

module knn_slot #(
    parameter int DIST_W  = 33,
    parameter int LABEL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               ins,
    input  logic [DIST_W-1:0]  d,
    input  logic [LABEL_W-1:0] label,
    input  logic               lt_below,
    input  logic [DIST_W-1:0]  below_dist,
    input  logic [LABEL_W-1:0] below_label,
    output logic               lt,
    output logic [DIST_W-1:0]  dist_q,
    output logic [LABEL_W-1:0] label_q
);
    // Strict compare keeps an earlier equal distance ahead of the new one.
    assign lt = d < dist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q  <= '1;
            label_q <= '0;
        end else if (clear) begin
            dist_q  <= '1;
            label_q <= '0;
        end else if (ins && lt) begin
            // List is sorted, so lt is monotonic: if the slot below also
            // loses to d, this slot takes the shifted-up entry from below.
            if (lt_below) begin
                dist_q  <= below_dist;
                label_q <= below_label;
            end else begin
                dist_q  <= d;
                label_q <= label;
            end
        end
    end
endmodule

module knn_sched #(
    parameter  int ADDR_W  = 8,
    parameter  int COORD_W = 16,
    parameter  int LABEL_W = 8,
    parameter  int K       = 4,
    localparam int DIST_W  = 2*COORD_W+1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W:0]              n_train,
    input  logic [COORD_W-1:0]           test_x,
    input  logic [COORD_W-1:0]           test_y,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [2*COORD_W+LABEL_W-1:0] mem_rdata,
    output logic                         dist_req_valid,
    input  logic                         dist_req_ready,
    output logic [2*COORD_W-1:0]         dist_a,
    output logic [2*COORD_W-1:0]         dist_b,
    input  logic                         dist_rsp_valid,
    input  logic [DIST_W-1:0]            dist_rsp_data,
    output logic [K*DIST_W-1:0]          nn_dist,
    output logic [K*LABEL_W-1:0]         nn_label,
    output logic [3:0]                   nn_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_REQ, S_WAIT_RSP, S_INSERT, S_DONE
    } state_t;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } train_t;

    state_t             state, state_nxt;
    logic [ADDR_W:0]    idx, idx_inc, n_lat;
    logic [COORD_W-1:0] tx, ty;
    train_t             tr;
    logic [DIST_W-1:0]  d_q;
    logic [3:0]         cnt;
    logic               accept, ins;

    logic [K-1:0][DIST_W-1:0]  slot_d;
    logic [K-1:0][LABEL_W-1:0] slot_l;
    logic [K-1:0]              lt;
    logic [K:0][DIST_W-1:0]    dist_ext;
    logic [K:0][LABEL_W-1:0]   label_ext;
    logic [K:0]                lt_ext;

    assign accept  = (state == S_IDLE) && start;
    assign ins     = (state == S_INSERT);
    assign idx_inc = idx + 1'b1;

    // Index 0 of the extended arrays is a sentinel below slot 0.
    assign dist_ext[0]  = '1;
    assign label_ext[0] = '0;
    assign lt_ext[0]    = 1'b0;

    for (genvar j = 0; j < K; j++) begin : g_slot
        assign dist_ext[j+1]  = slot_d[j];
        assign label_ext[j+1] = slot_l[j];
        assign lt_ext[j+1]    = lt[j];

        knn_slot #(.DIST_W(DIST_W), .LABEL_W(LABEL_W)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (accept),
            .ins         (ins),
            .d           (d_q),
            .label       (tr.label),
            .lt_below    (lt_ext[j]),
            .below_dist  (dist_ext[j]),
            .below_label (label_ext[j]),
            .lt          (lt[j]),
            .dist_q      (slot_d[j]),
            .label_q     (slot_l[j])
        );
    end

    assign nn_dist  = slot_d;
    assign nn_label = slot_l;
    assign nn_count = cnt;
    assign mem_addr = idx[ADDR_W-1:0];
    assign dist_a   = {ty, tx};
    assign dist_b   = {tr.y, tr.x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            n_lat <= '0;
            tx    <= '0;
            ty    <= '0;
            tr    <= '0;
            d_q   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                n_lat <= n_train;
                tx    <= test_x;
                ty    <= test_y;
                idx   <= '0;
                cnt   <= '0;
            end
            if (state == S_WAIT_MEM)
                tr <= mem_rdata;
            if (state == S_WAIT_RSP && dist_rsp_valid)
                d_q <= dist_rsp_data;
            if (ins) begin
                idx <= idx_inc;
                if (cnt != 4'(K))
                    cnt <= cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_en         = 1'b0;
        dist_req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (n_train == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                state_nxt = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                busy      = 1'b1;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                busy           = 1'b1;
                dist_req_valid = 1'b1;
                if (dist_req_ready)
                    state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                busy = 1'b1;
                if (dist_rsp_valid)
                    state_nxt = S_INSERT;
            end
            S_INSERT: begin
                busy      = 1'b1;
                state_nxt = (idx_inc == n_lat) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule
